// File: rtl/sobel_window_adr_gen.sv
// 3x3 window address generator: scans centre pixels (X outer, Y inner) and streams
// the nine tap addresses per centre. Define SOBEL_ADRGEN_BORDER_CLAMP_EN for full-image replicate-edge scan.
module sobel_window_adr_gen #(
  parameter int unsigned X_SIZE   = 100,
  parameter int unsigned Y_SIZE   = 100,
  parameter int unsigned BASE_ADR = 0,
  parameter int unsigned ADR_W    = 32
) (
  input  logic                      Clk_i,
  input  logic                      RstN_i,
  input  logic                      Start_i,
  input  logic                      Ready_i,
  output logic                      Valid_o,
  output logic [ADR_W-1:0]          Adr_o,
  output logic [3:0]                Tap_o,
  output logic [$clog2(X_SIZE)-1:0] CenX_o,
  output logic [$clog2(Y_SIZE)-1:0] CenY_o,
  output logic                      Last_o,
  output logic                      Busy_o,
  output logic                      Done_o
);

  localparam int XW = $clog2(X_SIZE);
  localparam int YW = $clog2(Y_SIZE);
  localparam int CW = ADR_W + XW + YW + 2;

`ifdef SOBEL_ADRGEN_BORDER_CLAMP_EN
  localparam logic [XW-1:0] X_FIRST = '0;
  localparam logic [XW-1:0] X_LAST  = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_FIRST = '0;
  localparam logic [YW-1:0] Y_LAST  = YW'(Y_SIZE - 1);
`else
  localparam logic [XW-1:0] X_FIRST = XW'(1);
  localparam logic [XW-1:0] X_LAST  = XW'(X_SIZE - 2);
  localparam logic [YW-1:0] Y_FIRST = YW'(1);
  localparam logic [YW-1:0] Y_LAST  = YW'(Y_SIZE - 2);
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     cx_q, cx_d;
  logic [YW-1:0]     cy_q, cy_d;
  logic [3:0]        tap_q, tap_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              beat;

  function automatic logic signed [1:0] tap_dx(input logic [3:0] tap);
    case (tap)
      4'd0, 4'd1, 4'd2: return 2'sb11;
      4'd3, 4'd4, 4'd5: return 2'sb00;
      default:          return 2'sb01;
    endcase
  endfunction

  function automatic logic signed [1:0] tap_dy(input logic [3:0] tap);
    case (tap)
      4'd0, 4'd3, 4'd6: return 2'sb11;
      4'd1, 4'd4, 4'd7: return 2'sb00;
      default:          return 2'sb01;
    endcase
  endfunction

`ifdef SOBEL_ADRGEN_BORDER_CLAMP_EN
  function automatic logic signed [XW+1:0] clamp_x(input logic signed [XW+1:0] v);
    if (v < 0) return '0;
    if (v > $signed((XW+2)'(X_SIZE - 1))) return (XW+2)'(X_SIZE - 1);
    return v;
  endfunction

  function automatic logic signed [YW+1:0] clamp_y(input logic signed [YW+1:0] v);
    if (v < 0) return '0;
    if (v > $signed((YW+2)'(Y_SIZE - 1))) return (YW+2)'(Y_SIZE - 1);
    return v;
  endfunction
`endif

  // Neighbour coordinates are formed signed so edge centres can step to -1 before clamping.
  function automatic logic [ADR_W-1:0] win_adr(input logic [XW-1:0] cx,
                                                input logic [YW-1:0] cy,
                                                input logic [3:0]    tap);
    logic signed [XW+1:0] nx;
    logic signed [YW+1:0] ny;
    logic [CW-1:0]        sum;
    nx = $signed({2'b00, cx}) + tap_dx(tap);
    ny = $signed({2'b00, cy}) + tap_dy(tap);
`ifdef SOBEL_ADRGEN_BORDER_CLAMP_EN
    nx = clamp_x(nx);
    ny = clamp_y(ny);
`endif
    sum = CW'(BASE_ADR) + CW'($unsigned(nx)) * CW'(Y_SIZE) + CW'($unsigned(ny));
    return sum[ADR_W-1:0];
  endfunction

  assign beat = valid_q & Ready_i;

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    tap_d   = tap_q;
    adr_d   = adr_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start_i) begin
          state_d = RUN;
          cx_d    = X_FIRST;
          cy_d    = Y_FIRST;
          tap_d   = 4'd0;
          adr_d   = win_adr(X_FIRST, Y_FIRST, 4'd0);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          last_d  = 1'b0;
        end
      end
      RUN: begin
        if (beat) begin
          if (last_q) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            if (tap_q == 4'd8) begin
              tap_d = 4'd0;
              if (cy_q == Y_LAST) begin
                cy_d = Y_FIRST;
                cx_d = cx_q + 1'b1;
              end else begin
                cy_d = cy_q + 1'b1;
              end
            end else begin
              tap_d = tap_q + 4'd1;
            end
            adr_d  = win_adr(cx_d, cy_d, tap_d);
            last_d = (tap_d == 4'd8) && (cx_d == X_LAST) && (cy_d == Y_LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or negedge RstN_i) begin
    if (!RstN_i) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      tap_q   <= '0;
      adr_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      tap_q   <= tap_d;
      adr_q   <= adr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Valid_o = valid_q;
  assign Adr_o   = adr_q;
  assign Tap_o   = tap_q;
  assign CenX_o  = cx_q;
  assign CenY_o  = cy_q;
  assign Last_o  = last_q;
  assign Busy_o  = busy_q;
  assign Done_o  = done_q;

endmodule
